aixh_mxc_left_qtile_ctrl: RTL and testbench
===========================================

Name: aixh_mxc_left_qtile_ctrl

Overview:
Control sequencer that sits directly upstream of the MxConv left queue-tile input-side cell column. It accepts the forward data stream and issues the vertical skew-enable, FIFO write and FIFO read controls with the correct latency alignment, together with per-beat route modes. It tracks queue occupancy so the tile FIFO never overflows or underflows.

Parameters:
FIFO_DEPTH, 8, entries in the tile read-data FIFO; must match the cell FIFO depth
WEN_LATENCY, 2, cycles from o_senable to the matching o_wenable (skew delay-buffer latency, SKEW_DEPTH+1); minimum 1
RMODE_LAG, 2, cycles from o_renable to the matching o_rmode beat
LEN_W, 8, width of the read command beat count

Ports:
aixh_core_clk  in  1  core clock; single clock domain
aixh_core_rst  in  1  reset, synchronous, active-high
s_valid  in  1  upstream forward-data beat valid
s_ready  out  1  beat accepted when s_valid && s_ready
cmd_valid  in  1  read command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_rmode  in  2  route mode for every beat of the command
cmd_len  in  LEN_W  beats to read; 0 is treated as 1
o_senable  out  1  skew-slice enable to cell column (= accepted input beat)
o_wenable  out  1  FIFO write enable to cell column
o_renable  out  1  FIFO read enable to cell column
o_rmode  out  2  route mode to cell column
o_cmd_done  out  1  one-cycle pulse after the last read beat of a command
o_level  out  $clog2(FIFO_DEPTH+1)  committed (written, unread) entries

Behaviour:
- Rmode encoding: 0 KEEP, 1 STRAIGHT, 2 DN_SHIFT, 3 UP_SHIFT.
- Reset (synchronous, checked at the clock edge): all outputs 0. s_ready=0 during reset and 1 the cycle after reset deasserts. cmd_ready=0 during reset. The delay shift registers are cleared, so in-flight writes are discarded. Both counters are set to 0 and the FSM goes to IDLE.
- Input side:
  - o_senable is combinational: o_senable = s_valid && s_ready.
  - o_wenable equals o_senable delayed by exactly WEN_LATENCY cycles through a cleared shift register.
- Two counters:
  - resv: reserved entries. +1 on o_senable, -1 on o_renable.
  - lvl: committed entries. +1 on o_wenable, -1 on o_renable.
  - When increment and decrement happen in the same cycle, the counter is unchanged.
  - s_ready = (resv < FIFO_DEPTH), registered-free compare on the current resv.
  - o_level = lvl.
  - resv never exceeds FIFO_DEPTH. lvl never exceeds resv and is never negative.
- FSM:
  - IDLE: cmd_ready=1. On accept, latch rmode and rem = max(cmd_len,1), then go to READ.
  - READ:
    - o_renable = (lvl != 0), combinational on the current lvl.
    - Each read beat decrements rem.
    - When the beat with rem==1 issues, go to DONE.
    - When lvl==0 the FSM stalls in READ with o_renable=0 and no timeout.
  - DONE: o_cmd_done=1 for one cycle, then go to IDLE. cmd_ready=0 in DONE, so there is a minimum 1 idle cycle between commands.
- The read side never issues o_renable when lvl==0, including the cycle in which o_wenable raises lvl from 0. The first read occurs the cycle after.
- Rmode pipeline:
  - A RMODE_LAG-deep shift register of {valid, rmode} is loaded with {o_renable, latched rmode}.
  - o_rmode = rmode at the output when valid, else KEEP (0).
  - So o_rmode for a beat appears exactly RMODE_LAG cycles after its o_renable, and is KEEP at all other times.
- A new command may start while the rmode pipeline still holds beats of the previous one. Each beat carries its own rmode.
- Input acceptance is independent of FSM state.

Test Plan:
- Reset then 3 back-to-back s_valid beats -> o_senable high cycles 1-3; o_wenable high cycles 3-5 (WEN_LATENCY=2); o_level steps 1,2,3; no o_renable.
- 8 accepted beats with no command -> s_ready=0 after the 8th beat; a 9th s_valid is held off; o_level reaches 8 two cycles later.
- With lvl=4, cmd len=4 rmode=2 -> o_renable high 4 consecutive cycles; o_rmode=2 on 4 cycles starting 2 cycles after the first read, otherwise 0; o_cmd_done pulses the cycle after the last read; o_level=0.
- Empty FIFO, cmd len=2 rmode=3 accepted, then 1 input beat -> first o_renable the cycle after o_wenable; FSM stalls until a 2nd beat is written; done only after the 2nd read.
- resv=8, same-cycle o_senable-eligible beat and o_renable -> beat accepted (s_ready was 1 after decrement? no: s_ready uses current resv=8 -> 0; the beat is accepted the next cycle); resv returns to 8.
- Assert aixh_core_rst mid-READ with in-flight writes -> next cycle all outputs 0, o_level=0, FSM IDLE, no late o_wenable or o_rmode beats emerge.

Source files
------------

// File: rtl/aixh_mxc_left_qtile_ctrl.sv
// aixh_mxc_left_qtile_ctrl
// Control sequencer feeding the MxConv left queue-tile input-side cell column.
// It accepts forward-data beats and issues the skew enable, the delayed FIFO
// write enable, and FIFO read enables with a lagged per-beat route mode. Two
// occupancy counters keep the tile FIFO from overflowing or underflowing:
//   resv - slots claimed by accepted beats, including writes still in the skew delay
//   lvl  - entries actually written and not yet read
// Ports:
//   aixh_core_clk / aixh_core_rst : clock, synchronous active-high reset
//   s_valid / s_ready              : forward-data beat handshake
//   cmd_valid / cmd_ready          : read command handshake
//   cmd_rmode, cmd_len             : route mode and beat count (0 means 1)
//   o_senable, o_wenable           : skew-slice enable, FIFO write enable
//   o_renable, o_rmode             : FIFO read enable, lagged route mode
//   o_cmd_done                     : pulse the cycle after a command's last read
//   o_level                        : committed FIFO entries
module aixh_mxc_left_qtile_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int WEN_LATENCY = 2,
    parameter int RMODE_LAG   = 2,
    parameter int LEN_W       = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             aixh_core_clk,
    input  logic             aixh_core_rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_rmode,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             o_senable,
    output logic             o_wenable,
    output logic             o_renable,
    output logic [1:0]       o_rmode,
    output logic             o_cmd_done,
    output logic [LVL_W-1:0] o_level
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [LEN_W-1:0]           rem_q, rem_d;
    logic [1:0]                 rmode_q, rmode_d;
    logic [LVL_W-1:0]           resv_q, resv_d;
    logic [LVL_W-1:0]           lvl_q, lvl_d;
    logic [WEN_LATENCY-1:0]     wen_sr_q, wen_sr_d;
    logic [RMODE_LAG-1:0]       vld_pipe_q, vld_pipe_d;
    logic [RMODE_LAG-1:0][1:0]  rm_pipe_q, rm_pipe_d;
    logic                       sen, wen, ren, has_room;

    always_comb begin
        // Every output is forced low while reset is held, even before the
        // registered state has been cleared by the reset edge.
        has_room = (resv_q < LVL_W'(FIFO_DEPTH));
        sen      = !aixh_core_rst && s_valid && has_room;
        wen      = !aixh_core_rst && wen_sr_q[WEN_LATENCY-1];
        // Reads look only at committed entries, so a write landing this cycle
        // becomes readable on the next one.
        ren      = !aixh_core_rst && (state_q == ST_READ) && (lvl_q != '0);

        s_ready    = !aixh_core_rst && has_room;
        cmd_ready  = !aixh_core_rst && (state_q == ST_IDLE);
        o_cmd_done = !aixh_core_rst && (state_q == ST_DONE);
        o_senable  = sen;
        o_wenable  = wen;
        o_renable  = ren;
        o_rmode    = (!aixh_core_rst && vld_pipe_q[RMODE_LAG-1]) ? rm_pipe_q[RMODE_LAG-1] : 2'd0;
        o_level    = aixh_core_rst ? '0 : lvl_q;
    end

    // Delay lines: write enable mirrors the skew buffer, rmode pipe lines up
    // each read beat's route mode with the cell's read data.
    always_comb begin
        wen_sr_d    = '0;
        wen_sr_d[0] = sen;
        for (int i = 1; i < WEN_LATENCY; i++) wen_sr_d[i] = wen_sr_q[i-1];

        vld_pipe_d    = '0;
        rm_pipe_d     = '0;
        vld_pipe_d[0] = ren;
        rm_pipe_d[0]  = rmode_q;
        for (int i = 1; i < RMODE_LAG; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            rm_pipe_d[i]  = rm_pipe_q[i-1];
        end
    end

    always_comb begin
        resv_d = resv_q;
        if (sen && !ren)      resv_d = resv_q + 1'b1;
        else if (!sen && ren) resv_d = resv_q - 1'b1;

        lvl_d = lvl_q;
        if (wen && !ren)      lvl_d = lvl_q + 1'b1;
        else if (!wen && ren) lvl_d = lvl_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        rmode_d = rmode_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    rmode_d = cmd_rmode;
                    rem_d   = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // Stalls here with no timeout while the FIFO is empty.
                if (ren) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aixh_core_clk) begin
        if (aixh_core_rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            rmode_q    <= '0;
            resv_q     <= '0;
            lvl_q      <= '0;
            wen_sr_q   <= '0;
            vld_pipe_q <= '0;
            rm_pipe_q  <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            rmode_q    <= rmode_d;
            resv_q     <= resv_d;
            lvl_q      <= lvl_d;
            wen_sr_q   <= wen_sr_d;
            vld_pipe_q <= vld_pipe_d;
            rm_pipe_q  <= rm_pipe_d;
        end
    end

endmodule

// File: tb/tb_aixh_mxc_left_qtile_ctrl.sv
// Testbench for aixh_mxc_left_qtile_ctrl: the stimulus process drives inputs
// once per cycle, advances a queue-based occupancy/command model and pushes
// the expected outputs for that cycle; a monitor pops and compares.
module tb_aixh_mxc_left_qtile_ctrl;
    localparam int FD  = 8;
    localparam int WL  = 2;
    localparam int RL  = 2;
    localparam int LW  = 8;
    localparam int LVW = $clog2(FD + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           s_valid = 1'b0;
    logic           cmd_valid = 1'b0;
    logic [1:0]     cmd_rmode = '0;
    logic [LW-1:0]  cmd_len = '0;
    logic           s_ready, cmd_ready, o_senable, o_wenable, o_renable, o_cmd_done;
    logic [1:0]     o_rmode;
    logic [LVW-1:0] o_level;

    aixh_mxc_left_qtile_ctrl #(.FIFO_DEPTH(FD), .WEN_LATENCY(WL), .RMODE_LAG(RL), .LEN_W(LW)) dut (
        .aixh_core_clk(clk), .aixh_core_rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rmode(cmd_rmode), .cmd_len(cmd_len),
        .o_senable(o_senable), .o_wenable(o_wenable), .o_renable(o_renable),
        .o_rmode(o_rmode), .o_cmd_done(o_cmd_done), .o_level(o_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic s_ready, cmd_ready, sen, wen, ren, done;
        logic [1:0] rm;
        int lvl;
        int cyc;
    } exp_t;
    typedef struct { int due; logic [1:0] rm; } rb_t;

    exp_t expq[$];
    int   wq[$];      // cycles at which accepted beats reach the FIFO
    rb_t  rmq[$];     // read beats waiting for their rmode slot
    int   m_resv, m_lvl, m_rem, m_cyc;
    bit   m_busy, m_done;
    logic [1:0] m_rm;
    int   tests = 0;
    int   fails = 0;

    task automatic step(input bit rs, input bit sv, input bit cv, input int len, input logic [1:0] rm);
        exp_t e;
        rb_t  r;
        @(posedge clk);
        #1;
        rst = rs; s_valid = sv; cmd_valid = cv; cmd_len = LW'(len); cmd_rmode = rm;
        e = '{default: 0};
        e.cyc = m_cyc;
        if (rs) begin
            m_resv = 0; m_lvl = 0; m_busy = 0; m_done = 0; m_rem = 0;
            wq.delete(); rmq.delete();
        end else begin
            e.s_ready   = (m_resv < FD);
            e.sen       = sv && e.s_ready;
            e.wen       = (wq.size() > 0) && (wq[0] == m_cyc);
            if (e.wen) void'(wq.pop_front());
            e.cmd_ready = !m_busy && !m_done;
            e.ren       = m_busy && (m_lvl > 0);
            e.done      = m_done;
            if (rmq.size() > 0 && rmq[0].due == m_cyc) begin
                e.rm = rmq[0].rm;
                void'(rmq.pop_front());
            end
            e.lvl = m_lvl;
            m_resv += int'(e.sen) - int'(e.ren);
            m_lvl  += int'(e.wen) - int'(e.ren);
            if (e.sen) wq.push_back(m_cyc + WL);
            if (e.ren) begin r.due = m_cyc + RL; r.rm = m_rm; rmq.push_back(r); end
            if (m_done) m_done = 0;
            else if (m_busy) begin
                if (e.ren) begin
                    m_rem--;
                    if (m_rem == 0) begin m_busy = 0; m_done = 1; end
                end
            end else if (cv) begin
                m_busy = 1; m_rm = rm; m_rem = (len == 0) ? 1 : len;
            end
        end
        expq.push_back(e);
        m_cyc++;
    endtask

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("s_ready",    e.cyc, 32'(s_ready),    32'(e.s_ready));
                chk("cmd_ready",  e.cyc, 32'(cmd_ready),  32'(e.cmd_ready));
                chk("o_senable",  e.cyc, 32'(o_senable),  32'(e.sen));
                chk("o_wenable",  e.cyc, 32'(o_wenable),  32'(e.wen));
                chk("o_renable",  e.cyc, 32'(o_renable),  32'(e.ren));
                chk("o_rmode",    e.cyc, 32'(o_rmode),    32'(e.rm));
                chk("o_cmd_done", e.cyc, 32'(o_cmd_done), 32'(e.done));
                chk("o_level",    e.cyc, 32'(o_level),    32'(e.lvl));
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 2'd0);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 2'd0);
    endtask

    initial begin
        int sv_pct, cv_pct;
        m_cyc = 0; m_resv = 0; m_lvl = 0; m_busy = 0; m_done = 0; m_rem = 0; m_rm = '0;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 2'd0);
        // Three back-to-back beats, then let them commit.
        beats(3); idle(6);
        // Fill to depth with s_valid held; extra beats must be held off.
        beats(12); idle(3);
        // Two len=4 DN_SHIFT commands drain the full FIFO.
        step(0, 0, 1, 4, 2'd2); idle(10);
        step(0, 0, 1, 4, 2'd2); idle(10);
        // Empty FIFO: command waits for writes, stalls between beats.
        step(0, 0, 1, 2, 2'd3); idle(3);
        beats(1); idle(5);
        beats(1); idle(6);
        // Full FIFO with continuous input while reading; len 0 means 1.
        beats(12);
        step(0, 1, 1, 5, 2'd1); beats(12);
        step(0, 1, 1, 0, 2'd2); beats(6); idle(12);
        // Reset in the middle of a long read with writes in flight.
        beats(4);
        step(0, 1, 1, 200, 2'd1); beats(6);
        step(1, 1, 0, 0, 2'd0); step(1, 1, 1, 3, 2'd3);
        idle(6);
        // Randomized segments with occasional resets.
        for (int seg = 0; seg < 40; seg++) begin
            sv_pct = $urandom_range(5, 100);
            cv_pct = $urandom_range(5, 100);
            for (int i = 0; i < 64; i++)
                step(($urandom_range(0, 399) == 0),
                     ($urandom_range(1, 100) <= sv_pct),
                     ($urandom_range(1, 100) <= cv_pct),
                     $urandom_range(0, 12), 2'($urandom_range(0, 3)));
        end
        idle(4);
        repeat (3) @(posedge clk);
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d exp=0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
